axi_araw_push: RTL and testbench

- Master-side front end of the AR/AW clock-crossing path.
- Accepts AXI read-address (AR) and write-address (AW) channels from one master port and arbitrates them round-robin.
- Packs the winner into one tagged word and pushes it into the write side of the master ARAW async FIFO (wdata/wpush/wfull).
- Runs entirely in the master (write-side) clock domain.

---
 rtl/axi_araw_push.sv | 117 +++++++++++
 tb/tb_axi_araw_push.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_araw_push.sv
// AR/AW round-robin arbiter that packs the granted address beat into a tagged word for the ARAW async FIFO write port.
// Optional macro ARAW_OUTSTANDING_LIMIT_EN caps outstanding reads/writes at MAX_OUTS each.
module axi_araw_push #(
  parameter int unsigned ID_W     = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned SIZE_W   = 3,
  parameter int unsigned BURST_W  = 2,
  parameter int unsigned DATA_W   = 46,
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    ARID,
  input  logic [ADDR_W-1:0]  ARADDR,
  input  logic [LEN_W-1:0]   ARLEN,
  input  logic [SIZE_W-1:0]  ARSIZE,
  input  logic [BURST_W-1:0] ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  input  logic [ID_W-1:0]    AWID,
  input  logic [ADDR_W-1:0]  AWADDR,
  input  logic [LEN_W-1:0]   AWLEN,
  input  logic [SIZE_W-1:0]  AWSIZE,
  input  logic [BURST_W-1:0] AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic               rdone,
  input  logic               bdone,
  output logic [DATA_W-1:0]  wdata,
  output logic               wpush,
  input  logic               wfull
);

  logic              hold_v;
  logic [DATA_W-1:0] hold_data;
  logic              prio;
  logic              rd_ok, wr_ok;
  logic              ar_el, aw_el;
  logic              grant_ar, grant_aw;
  logic              can_accept;
  logic              ar_hs, aw_hs;
  logic [DATA_W-1:0] ar_word, aw_word;

  assign ar_word = {1'b0, ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
  assign aw_word = {1'b1, AWID, AWADDR, AWLEN, AWSIZE, AWBURST};

  assign wpush      = hold_v & ~wfull;
  assign wdata      = hold_data;
  // A full holding register may refill in the same cycle it drains.
  assign can_accept = ~hold_v | ~wfull;

  assign ar_el    = ARVALID & rd_ok;
  assign aw_el    = AWVALID & wr_ok;
  assign grant_ar = ar_el & (~aw_el | ~prio);
  assign grant_aw = aw_el & (~ar_el | prio);

  assign ARREADY = ~rst & can_accept & grant_ar;
  assign AWREADY = ~rst & can_accept & grant_aw;
  assign ar_hs   = ARVALID & ARREADY;
  assign aw_hs   = AWVALID & AWREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_data <= '0;
      prio      <= 1'b0;
    end else begin
      if (ar_hs) begin
        hold_v    <= 1'b1;
        hold_data <= ar_word;
        prio      <= 1'b1;
      end else if (aw_hs) begin
        hold_v    <= 1'b1;
        hold_data <= aw_word;
        prio      <= 1'b0;
      end else if (wpush) begin
        hold_v <= 1'b0;
      end
    end
  end

`ifdef ARAW_OUTSTANDING_LIMIT_EN
  localparam int unsigned CW = $clog2(MAX_OUTS + 1);

  logic [CW-1:0] rd_cnt, wr_cnt;
  logic          rd_dec, wr_dec;

  // Completions arriving at a zero count are dropped rather than wrapping.
  assign rd_dec = rdone & (rd_cnt != '0);
  assign wr_dec = bdone & (wr_cnt != '0);
  assign rd_ok  = (rd_cnt != CW'(MAX_OUTS));
  assign wr_ok  = (wr_cnt != CW'(MAX_OUTS));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (ar_hs && !rd_dec)
        rd_cnt <= rd_cnt + CW'(1);
      else if (!ar_hs && rd_dec)
        rd_cnt <= rd_cnt - CW'(1);
      if (aw_hs && !wr_dec)
        wr_cnt <= wr_cnt + CW'(1);
      else if (!aw_hs && wr_dec)
        wr_cnt <= wr_cnt - CW'(1);
    end
  end
`else
  logic unused_done;
  assign unused_done = rdone ^ bdone ^ (MAX_OUTS == 0);
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
`endif

endmodule

// File: tb/tb_axi_araw_push.sv
// Directed bench for axi_araw_push: expected FIFO words are queued at each expected handshake and checked on wpush.
module tb_axi_araw_push;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ARID, AWID;
  logic [31:0] ARADDR, AWADDR;
  logic [3:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, AWVALID, ARREADY, AWREADY;
  logic        rdone, bdone;
  logic [45:0] wdata;
  logic        wpush, wfull;

  int tests = 0;
  int fails = 0;
  logic [45:0] exp_q[$];

  axi_araw_push #(
    .ID_W(4), .ADDR_W(32), .LEN_W(4), .SIZE_W(3), .BURST_W(2),
    .DATA_W(46), .MAX_OUTS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .rdone(rdone), .bdone(bdone),
    .wdata(wdata), .wpush(wpush), .wfull(wfull)
  );

  always #5 clk = ~clk;

  function automatic logic [45:0] pack(input logic w, input logic [3:0] id, input logic [31:0] a,
                                       input logic [3:0] l, input logic [2:0] s, input logic [1:0] b);
    return {w, id, a, l, s, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    ARID = id; ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b;
  endtask

  task automatic drive_aw(input logic [3:0] id, input logic [31:0] a, input logic [3:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    AWID = id; AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = b;
  endtask

  // Check both READYs; queue the word the bench expects to be accepted (track=0 for words never pushed).
  task automatic expect_rdy(input string tag, input logic ar, input logic aw, input bit track);
    chk({tag, "_arready"}, 64'(ARREADY), 64'(ar));
    chk({tag, "_awready"}, 64'(AWREADY), 64'(aw));
    if (track && ar) exp_q.push_back(pack(1'b0, ARID, ARADDR, ARLEN, ARSIZE, ARBURST));
    if (track && aw) exp_q.push_back(pack(1'b1, AWID, AWADDR, AWLEN, AWSIZE, AWBURST));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      assert (!(wpush && wfull)) else begin
        fails++;
        $error("FAIL push_while_full observed=1 expected=0");
      end
      if (wpush) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_push observed=%h expected=none", wdata);
        end
        if (exp_q.size() != 0) chk("wdata", 64'(wdata), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; wfull = 1'b0; rdone = 1'b0; bdone = 1'b0;
    ARVALID = 1'b1; AWVALID = 1'b1;
    drive_ar(4'h0, 32'h0, 4'h0, 3'h0, 2'h0);
    drive_aw(4'h0, 32'h0, 4'h0, 3'h0, 2'h0);
    tick(); tick();
    expect_rdy("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_wpush", 64'(wpush), 64'd0);
    chk("reset_wdata", 64'(wdata), 64'd0);

    // Single AR after reset release
    rst = 1'b0; AWVALID = 1'b0;
    drive_ar(4'h3, 32'h1000_0040, 4'h3, 3'h2, 2'h1);
    #1 expect_rdy("t1", 1'b1, 1'b0, 1'b1);
    chk("t1_word_queued", 64'(exp_q[0]), 64'({1'b0, 4'h3, 32'h1000_0040, 4'h3, 3'h2, 2'h1}));
    tick();
    ARVALID = 1'b0;
    #1 chk("t1_wpush", 64'(wpush), 64'd1);
    tick();
    chk("t1_idle", 64'(wpush), 64'd0);

    // Back-to-back AW stream of 8
    AWVALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_aw(4'(i), 32'h2000_0000 + 32'(i * 16), 4'(i), 3'(i), 2'(i % 3));
      #1 expect_rdy($sformatf("t4_%0d", i), 1'b0, 1'b1, 1'b1);
      if (i > 0) chk($sformatf("t4_wpush_%0d", i), 64'(wpush), 64'd1);
      tick();
    end
    AWVALID = 1'b0;
    #1 chk("t4_wpush_last", 64'(wpush), 64'd1);
    tick();
    chk("t4_idle", 64'(wpush), 64'd0);

    // Both channels requesting: grants alternate starting with AR
    ARVALID = 1'b1; AWVALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_ar(4'(8 + k), 32'h3000_0000 + 32'(k), 4'(k), 3'h1, 2'h1);
      drive_aw(4'(12 + k), 32'h4000_0000 + 32'(k), 4'(k + 4), 3'h2, 2'h2);
      #1 expect_rdy($sformatf("t2_%0d", k), 1'((k % 2) == 0), 1'((k % 2) == 1), 1'b1);
      tick();
    end
    ARVALID = 1'b0; AWVALID = 1'b0;
    #1 chk("t2_wpush_last", 64'(wpush), 64'd1);
    tick();

    // Backpressure: hold filled, then wfull for 5 cycles
    AWVALID = 1'b1;
    drive_aw(4'hA, 32'h5000_0000, 4'h1, 3'h3, 2'h1);
    #1 expect_rdy("t3_fill", 1'b0, 1'b1, 1'b1);
    tick();
    wfull = 1'b1;
    drive_aw(4'hB, 32'h5000_0100, 4'h2, 3'h3, 2'h1);
    for (int k = 0; k < 5; k++) begin
      #1 expect_rdy($sformatf("t3_full_%0d", k), 1'b0, 1'b0, 1'b0);
      chk($sformatf("t3_full_wpush_%0d", k), 64'(wpush), 64'd0);
      tick();
    end
    wfull = 1'b0;
    #1 chk("t3_release_wpush", 64'(wpush), 64'd1);
    expect_rdy("t3_release", 1'b0, 1'b1, 1'b1);
    tick();
    AWVALID = 1'b0;
    #1 chk("t3_next_wpush", 64'(wpush), 64'd1);
    tick();
    chk("t3_idle", 64'(wpush), 64'd0);

    // Reset while a word is held behind a full FIFO
    AWVALID = 1'b1;
    drive_aw(4'hD, 32'hDEAD_0000, 4'h7, 3'h1, 2'h0);
    #1 expect_rdy("t5_hs", 1'b0, 1'b1, 1'b0);
    tick();
    AWVALID = 1'b0; wfull = 1'b1; rst = 1'b1;
    #1 chk("t5_held_wpush", 64'(wpush), 64'd0);
    tick();
    rst = 1'b0; wfull = 1'b0;
    #1 chk("t5_after_wpush", 64'(wpush), 64'd0);
    chk("t5_after_wdata", 64'(wdata), 64'd0);
    tick();
    chk("t5_after2_wpush", 64'(wpush), 64'd0);
    ARVALID = 1'b1;
    drive_ar(4'hE, 32'hE000_0004, 4'h0, 3'h2, 2'h1);
    #1 expect_rdy("t5_new", 1'b1, 1'b0, 1'b1);
    tick();
    ARVALID = 1'b0;
    #1 chk("t5_new_wpush", 64'(wpush), 64'd1);
    tick();

`ifdef ARAW_OUTSTANDING_LIMIT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; ARVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_ar(4'(i), 32'h6000_0000 + 32'(i * 64), 4'h1, 3'h2, 2'h1);
      #1 expect_rdy($sformatf("t6_ar_%0d", i), 1'b1, 1'b0, 1'b1);
      tick();
    end
    AWVALID = 1'b1;
    drive_aw(4'h9, 32'h7000_0000, 4'h0, 3'h2, 2'h1);
    #1 expect_rdy("t6_limit", 1'b0, 1'b1, 1'b1);
    tick();
    AWVALID = 1'b0; rdone = 1'b1;
    #1 expect_rdy("t6_rdone", 1'b0, 1'b0, 1'b1);
    tick();
    rdone = 1'b0;
    drive_ar(4'h5, 32'h6000_1000, 4'h2, 3'h2, 2'h1);
    #1 expect_rdy("t6_freed", 1'b1, 1'b0, 1'b1);
    tick();
    ARVALID = 1'b0; rdone = 1'b1;
    tick();
    ARVALID = 1'b1;
    drive_ar(4'h6, 32'h6000_2000, 4'h3, 3'h2, 2'h1);
    #1 expect_rdy("t6_coincide", 1'b1, 1'b0, 1'b1);
    tick();
    rdone = 1'b0;
    drive_ar(4'h7, 32'h6000_3000, 4'h4, 3'h2, 2'h1);
    #1 expect_rdy("t6_fourth", 1'b1, 1'b0, 1'b1);
    tick();
    #1 expect_rdy("t6_full_again", 1'b0, 1'b0, 1'b0);
    ARVALID = 1'b0;
    tick();
`endif

    tick(); tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
